signed_display_driver: RTL and testbench

Multi-digit, time-multiplexed seven-segment driver for signed two's-complement values. It is the parametrised successor of the single-digit signed decoder. It converts a loaded value to sign plus magnitude, in decimal (serial double-dabble) or hexadecimal. It then scans the digits onto a shared segment bus with per-digit anode enables, and sits between datapath result registers and the board display pins.

---
 rtl/display_pkg.sv | 42 ++++
 rtl/bin2bcd_serial.sv | 66 ++++++
 rtl/signed_display_driver.sv | 149 ++++++++++++++
 tb/tb_signed_display_driver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Seven-segment glyphs, FSM state type and sizing helpers shared by the
// signed display driver and its serial BCD converter.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  // Active-low glyphs for 0..F with bit 6 = segment a; entry n sits at index n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  // Decimal digits needed for the largest magnitude, 2^(bits-1).
  function automatic int dec_digits(input int bits);
    longint unsigned v;
    int              n;
    v = 64'd1 << (bits - 1);
    n = 1;
    v = v / 10;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per cycle, IN_W steps.
// done_o marks the cycle of the final shift; bcd_o is complete from the next cycle.
module bin2bcd_serial #(
  parameter int IN_W = 8,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [IN_W-1:0]   bin_i,
  output logic              done_o,
  output logic [4*NDIG-1:0] bcd_o
);

  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

  logic [IN_W-1:0]   shreg_q, shreg_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              last;

  assign last = active_q && (cnt_q == CW'(IN_W - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start_i) begin
      shreg_d  = bin_i;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, shreg_d} = {adj, shreg_q} << 1;
      cnt_d            = cnt_q + 1'b1;
      if (last) active_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = last;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/signed_display_driver.sv
// Signed value -> sign/magnitude -> decimal or hex digits, scanned onto a
// shared active-low segment bus with one-hot-low anode enables.
module signed_display_driver
  import display_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   value_i,
  input  logic              load_i,
  input  logic              hex_mode_i,
  output logic              busy_o,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int NDIG = dec_digits(IN_W);
  localparam int HDIG = (IN_W + 3) / 4;
  localparam int MD   = DIGITS - 1;
  localparam int WD   = max3(NDIG, HDIG, MD);
  localparam int PW   = $clog2(REFRESH_DIV);
  localparam int IW   = $clog2(DIGITS);

  state_e            state_q, state_d;
  logic              hex_q, hex_d, sign_q, sign_d;
  logic [IN_W-1:0]   mag_q, mag_d, mag_in;
  logic [4*MD-1:0]   disp_dig_q, disp_dig_d;
  logic              disp_neg_q, disp_neg_d, disp_ovf_q, disp_ovf_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d, glyph;
  logic [DIGITS-1:0] an_q, an_d;
  logic              conv_start, conv_done, wrap, upper_nz;
  logic [4*NDIG-1:0] bcd;
  logic [4*WD-1:0]   src;
  logic [3:0]        nib;

  // Most negative input maps to 2^(IN_W-1), which still fits as unsigned.
  assign mag_in     = value_i[IN_W-1] ? (~value_i + 1'b1) : value_i;
  assign conv_start = (state_q == IDLE) && load_i && !hex_mode_i;

  bin2bcd_serial #(.IN_W(IN_W), .NDIG(NDIG)) u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(conv_start),
    .bin_i  (mag_in),
    .done_o (conv_done),
    .bcd_o  (bcd)
  );

  always_comb begin
    src = '0;
    if (hex_q) src[IN_W-1:0]   = mag_q;
    else       src[4*NDIG-1:0] = bcd;
  end

  always_comb begin
    state_d    = state_q;
    hex_d      = hex_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    disp_dig_d = disp_dig_q;
    disp_neg_d = disp_neg_q;
    disp_ovf_d = disp_ovf_q;
    case (state_q)
      IDLE: if (load_i) begin
        state_d = CONV;
        hex_d   = hex_mode_i;
        sign_d  = value_i[IN_W-1];
        mag_d   = mag_in;
      end
      CONV: if (hex_q || conv_done) state_d = COMMIT;
      COMMIT: begin
        disp_dig_d = src[4*MD-1:0];
        disp_neg_d = sign_q;
        disp_ovf_d = |(src >> (4*MD));
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Glyph for the digit being scanned in, taken from next-state display values
  // so a commit on a wrap edge is shown immediately.
  always_comb begin
    nib      = 4'd0;
    upper_nz = 1'b0;
    for (int i = 0; i < MD; i++) begin
      if (idx_q == IW'(i)) begin
        nib      = disp_dig_d[4*i +: 4];
        upper_nz = |(disp_dig_d >> (4*i));
      end
    end
    if (disp_ovf_d)                   glyph = SEG_MINUS;
    else if (idx_q == IW'(DIGITS-1))  glyph = disp_neg_d ? SEG_MINUS : SEG_BLANK;
    else if (idx_q == '0 || upper_nz) glyph = seg_encode(nib);
    else                              glyph = SEG_BLANK;
  end

  always_comb begin
    wrap  = (pre_q == PW'(REFRESH_DIV - 1));
    pre_d = wrap ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    seg_d = seg_q;
    an_d  = an_q;
    if (wrap) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      seg_d = glyph;
      an_d  = ~(DIGITS'(1) << idx_q);
    end
  end

  // NOTE: display registers are reset explicitly so power-up shows "0", not garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hex_q      <= 1'b0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      disp_dig_q <= '0;
      disp_neg_q <= 1'b0;
      disp_ovf_q <= 1'b0;
      pre_q      <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      hex_q      <= hex_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      disp_dig_q <= disp_dig_d;
      disp_neg_q <= disp_neg_d;
      disp_ovf_q <= disp_ovf_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign seg_o  = seg_q;
  assign an_o   = an_q;

endmodule

// File: tb/tb_signed_display_driver.sv
// Bench for signed_display_driver: a cycle model built from integer arithmetic
// checks every cycle; a 3-digit instance covers the overflow display.
module tb_signed_display_driver;

  localparam int IN_W = 8;
  localparam int RD   = 4;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b1111110;
  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_i = 1'b0;
  logic            hex_mode_i = 1'b0;
  logic [IN_W-1:0] value_i = '0;
  logic            busy_o, busy_b;
  logic [6:0]      seg_o, seg_b;
  logic [3:0]      an_o;
  logic [2:0]      an_b;

  always #5 clk = ~clk;

  signed_display_driver #(.IN_W(IN_W), .DIGITS(4), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
    .hex_mode_i(hex_mode_i), .busy_o(busy_o), .seg_o(seg_o), .an_o(an_o)
  );

  signed_display_driver #(.IN_W(IN_W), .DIGITS(3), .REFRESH_DIV(RD)) dut_b (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
    .hex_mode_i(hex_mode_i), .busy_o(busy_b), .seg_o(seg_b), .an_o(an_b)
  );

  int total = 0;
  int bad   = 0;

  // Model state: what is on display, what is pending, scan position.
  int         rem = 0, pre = 0, idx = 0, disp_v = 0, pend_v = 0;
  bit         disp_hex = 1'b0, pend_hex = 1'b0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = BL;
  logic [6:0] seen_a [4];
  logic [6:0] seen_b [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [6:0] exp_glyph(input int v, input bit hex, input int nd, input int pos);
    int m, base, lim, w;
    m    = (v < 0) ? -v : v;
    base = hex ? 16 : 10;
    lim  = 1;
    for (int k = 0; k < nd - 1; k++) lim *= base;
    if (m >= lim) return MI;
    if (pos == nd - 1) return (v < 0) ? MI : BL;
    w = 1;
    for (int k = 0; k < pos; k++) w *= base;
    if (pos != 0 && m < w) return BL;
    return GLYPH_TAB[(m / w) % base];
  endfunction

  task automatic model_reset();
    rem = 0; pre = 0; idx = 0; disp_v = 0; disp_hex = 1'b0;
    exp_an = 4'hF; exp_seg = BL;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        disp_v   = pend_v;
        disp_hex = pend_hex;
      end
    end else if (load_i) begin
      pend_v   = int'($signed(value_i));
      pend_hex = hex_mode_i;
      rem      = hex_mode_i ? 2 : IN_W + 1;
    end
    if (pre == RD - 1) begin
      exp_an  = ~(4'b0001 << idx);
      exp_seg = exp_glyph(disp_v, disp_hex, 4, idx);
      idx     = (idx + 1) % 4;
      pre     = 0;
    end else begin
      pre++;
    end
    @(negedge clk);
    check("busy", busy_o, rem > 0);
    check("an", an_o, exp_an);
    check("seg", seg_o, exp_seg);
    for (int i = 0; i < 4; i++) if (an_o == ~(4'b0001 << i)) seen_a[i] = seg_o;
    for (int i = 0; i < 3; i++) if (an_b == ~(3'b001 << i)) seen_b[i] = seg_b;
  endtask

  task automatic load(input logic [7:0] v, input logic hx);
    value_i = v; hex_mode_i = hx; load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  task automatic busy_len(input string tag, input int want);
    int n;
    n = busy_o ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (busy_o) n++;
    end
    check(tag, n, want);
  endtask

  task automatic collect();
    for (int i = 0; i < 4; i++) seen_a[i] = 'x;
    for (int i = 0; i < 3; i++) seen_b[i] = 'x;
    repeat (20) tick();
  endtask

  task automatic expect_a(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                          input logic [6:0] d1, input logic [6:0] d0);
    check({tag, "_d3"}, seen_a[3], d3);
    check({tag, "_d2"}, seen_a[2], d2);
    check({tag, "_d1"}, seen_a[1], d1);
    check({tag, "_d0"}, seen_a[0], d0);
  endtask

  task automatic expect_b(input string tag, input logic [6:0] d2, input logic [6:0] d1,
                          input logic [6:0] d0);
    check({tag, "_b2"}, seen_b[2], d2);
    check({tag, "_b1"}, seen_b[1], d1);
    check({tag, "_b0"}, seen_b[0], d0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_an", an_o, 4'hF);
    check("rst_seg", seg_o, BL);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) seen_a[i] = 'x;
    repeat (40) tick();
    expect_a("idle", BL, BL, BL, 7'b0000001);

    load(8'd127, 1'b0);
    busy_len("busy_127", 9);
    collect();
    expect_a("p127", BL, 7'b1001111, 7'b0010010, 7'b0001111);
    expect_b("p127", MI, MI, MI);

    load(8'h80, 1'b0);
    busy_len("busy_m128", 9);
    collect();
    expect_a("m128", MI, 7'b1001111, 7'b0010010, 7'b0000000);
    expect_b("m128", MI, MI, MI);

    load(8'hF5, 1'b1);
    busy_len("busy_hex", 2);
    collect();
    expect_a("m11h", MI, BL, BL, 7'b1100000);
    expect_b("m11h", MI, BL, 7'b1100000);

    load(8'd5, 1'b0);
    value_i = 8'd9; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    repeat (12) tick();
    collect();
    expect_a("drop9", BL, BL, BL, 7'b0100100);
    load(8'd9, 1'b0);
    repeat (12) tick();
    collect();
    expect_a("take9", BL, BL, BL, 7'b0000100);

    load(8'd99, 1'b0);
    repeat (12) tick();
    collect();
    expect_b("p99", BL, 7'b0000100, 7'b0000100);
    load(8'h9C, 1'b1);
    repeat (12) tick();
    collect();
    expect_b("m100h", MI, 7'b0100000, 7'b1001100);

    for (int n = 0; n < 40; n++) begin
      value_i    = 8'($urandom_range(0, 255));
      hex_mode_i = 1'($urandom_range(0, 1));
      load_i     = 1'b1;
      tick();
      load_i = 1'b0;
      repeat ($urandom_range(0, 12)) tick();
    end
    repeat (12) tick();

    load(8'd99, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_an", an_o, 4'hF);
    check("midrst_seg", seg_o, BL);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) tick();
    collect();
    expect_a("after_rst", BL, BL, BL, 7'b0000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
